add_int_seq: RTL and testbench

Sequential multi-precision integer adder/subtractor built around one `cla_64bits` instance, used one 64-bit limb per cycle. It accepts wide operands over a valid/ready handshake and chains the carry between limbs in a register. It presents the registered sum and flags on a second valid/ready port. It is the operand-sequencing and carry-chaining stage directly upstream of the 64-bit carry-lookahead adder, for widths the single adder cannot cover.

---
 rtl/add_int_pkg.sv | 40 ++++
 rtl/cla_64bits.sv | 49 ++++
 rtl/add_int_seq.sv | 158 +++++++++++++++
 tb/tb_add_int_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_int_pkg.sv
// add_int_pkg: shared types, constants and carry-lookahead helpers for the
// sequential multi-limb adder and its 64-bit lookahead adder.
package add_int_pkg;

    localparam int unsigned LIMB_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Limb index width; a single-limb build still keeps a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned limbs);
        return (limbs > 1) ? $clog2(limbs) : 1;
    endfunction

    // Carries into each of four positions given generate/propagate and carry-in.
    function automatic logic [3:0] cla4_carry(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       cin
    );
        logic [3:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    // Group generate of a four-wide slice.
    function automatic logic cla4_gen(
        input logic [3:0] g,
        input logic [3:0] p
    );
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla_64bits.sv
// cla_64bits: three-level 64-bit carry-lookahead adder (4-bit groups, 16-bit
// sections, full word). Exposes the block generate/propagate so the caller
// forms the carry-out itself.
module cla_64bits
    import add_int_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    output logic [LIMB_W-1:0] s,
    output logic              gm,
    output logic              pm
);

    logic [LIMB_W-1:0] g;
    logic [LIMB_W-1:0] p;
    logic [LIMB_W-1:0] c;
    logic [15:0]       g1;
    logic [15:0]       p1;
    logic [15:0]       c1;
    logic [3:0]        g2;
    logic [3:0]        p2;
    logic [3:0]        c2;

    // Bit, group and section generate/propagate, then carries pushed back down.
    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int unsigned i = 0; i < 16; i++) begin
            g1[i] = cla4_gen(g[4*i +: 4], p[4*i +: 4]);
            p1[i] = &p[4*i +: 4];
        end
        for (int unsigned j = 0; j < 4; j++) begin
            g2[j] = cla4_gen(g1[4*j +: 4], p1[4*j +: 4]);
            p2[j] = &p1[4*j +: 4];
        end
        gm = cla4_gen(g2, p2);
        pm = &p2;
        c2 = cla4_carry(g2, p2, cin);
        for (int unsigned j = 0; j < 4; j++) begin
            c1[4*j +: 4] = cla4_carry(g1[4*j +: 4], p1[4*j +: 4], c2[j]);
        end
        for (int unsigned i = 0; i < 16; i++) begin
            c[4*i +: 4] = cla4_carry(g[4*i +: 4], p[4*i +: 4], c1[i]);
        end
        s = p ^ c;
    end

endmodule

// File: rtl/add_int_seq.sv
// add_int_seq: sequential multi-precision adder/subtractor, one 64-bit limb
// per cycle through a single cla_64bits, carry chained in a register.
// Define ADD_INT_SEQ_OVF_EN to add the registered signed-overflow output out_ovf.
module add_int_seq
    import add_int_pkg::*;
#(
    parameter int unsigned LIMBS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sub,
    input  logic [LIMB_W*LIMBS-1:0] in_a,
    input  logic [LIMB_W*LIMBS-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LIMB_W*LIMBS-1:0] out_s,
    output logic                    out_cout
`ifdef ADD_INT_SEQ_OVF_EN
    ,
    output logic                    out_ovf
`endif
);

    localparam int unsigned       IDX_W    = idx_width(LIMBS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LIMBS - 1);

    state_e                         state_q;
    state_e                         state_d;
    logic [LIMBS-1:0][LIMB_W-1:0]   a_q;
    logic [LIMBS-1:0][LIMB_W-1:0]   a_d;
    logic [LIMBS-1:0][LIMB_W-1:0]   b_q;
    logic [LIMBS-1:0][LIMB_W-1:0]   b_d;
    logic [LIMBS-1:0][LIMB_W-1:0]   s_q;
    logic [LIMBS-1:0][LIMB_W-1:0]   s_d;
    logic                           carry_q;
    logic                           carry_d;
    logic [IDX_W-1:0]               idx_q;
    logic [IDX_W-1:0]               idx_d;
`ifdef ADD_INT_SEQ_OVF_EN
    logic                           ovf_q;
    logic                           ovf_d;
`endif

    logic [LIMB_W-1:0]              limb_a;
    logic [LIMB_W-1:0]              limb_b;
    logic [LIMB_W-1:0]              limb_s;
    logic                           gm;
    logic                           pm;

    // Limb select: decoded mux on idx_q, operand registers stay in place.
    always_comb begin
        limb_a = '0;
        limb_b = '0;
        for (int unsigned k = 0; k < LIMBS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                limb_a = a_q[k];
                limb_b = b_q[k];
            end
        end
    end

    cla_64bits u_cla (
        .a   (limb_a),
        .b   (limb_b),
        .cin (carry_q),
        .s   (limb_s),
        .gm  (gm),
        .pm  (pm)
    );

    // Next-state: accept in IDLE, one limb per RUN cycle, hold in DONE until consumed.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        idx_d   = idx_q;
`ifdef ADD_INT_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned k = 0; k < LIMBS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        s_d[k] = limb_s;
                    end
                end
                carry_d = gm | (pm & carry_q);
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
`ifdef ADD_INT_SEQ_OVF_EN
                    ovf_d   = (limb_a[LIMB_W-1] == limb_b[LIMB_W-1]) &&
                              (limb_s[LIMB_W-1] != limb_a[LIMB_W-1]);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
`ifdef ADD_INT_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
`ifdef ADD_INT_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Handshakes from state; results are only visible while DONE, so a
    // partially built sum never reaches the port.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_s     = (state_q == DONE) ? s_q : '0;
        out_cout  = (state_q == DONE) & carry_q;
`ifdef ADD_INT_SEQ_OVF_EN
        out_ovf   = (state_q == DONE) & ovf_q;
`endif
    end

endmodule

// File: tb/tb_add_int_seq.sv
// tb_add_int_seq: scoreboard bench for add_int_seq at LIMBS = 1, 2 and 4.
// Define ADD_INT_SEQ_OVF_EN for both bench and RTL to cover out_ovf.
module tb_add_int_seq;

    typedef struct {
        logic [255:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    localparam int NREQ = 2000;

    localparam logic [255:0] DIR_A [6] = '{256'hFFFF_FFFF_FFFF_FFFF, 256'd5, 256'd7,
                                           256'd1 << 127, 256'd1 << 126, {256{1'b1}}};
    localparam logic [255:0] DIR_B [6] = '{256'd1, 256'd7, 256'd5,
                                           256'd1 << 127, 256'd1 << 126, 256'd1};
    localparam logic         DIR_SUB [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input int lane_id, input string nm,
                         input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL lane%0d %s: got %0h expected %0h", lane_id, nm, got, exp);
        end
    endtask

    // Reference: plain W-bit unsigned arithmetic and signed-overflow rule.
    function automatic exp_t model(input int unsigned w, input logic [255:0] a_in,
                                   input logic [255:0] b_in, input logic sub);
        exp_t         e;
        logic [256:0] mask;
        logic [256:0] wide;
        logic [255:0] a;
        logic [255:0] b;
        mask = (257'd1 << w) - 257'd1;
        a    = a_in & mask[255:0];
        b    = b_in & mask[255:0];
        if (!sub) begin
            wide   = {1'b0, a} + {1'b0, b};
            e.cout = wide[w];
        end else begin
            wide   = {1'b0, a} - {1'b0, b};
            e.cout = (a >= b);
        end
        e.s = wide[255:0] & mask[255:0];
        if (!sub) e.ovf = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
        else      e.ovf = (a[w-1] != b[w-1]) && (e.s[w-1] != a[w-1]);
        return e;
    endfunction

    function automatic logic [255:0] rnd_val();
        logic [255:0] v;
        int unsigned  m;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0:       v[32*i +: 32] = '0;
                1:       v[32*i +: 32] = '1;
                default: v[32*i +: 32] = $urandom;
            endcase
        end
        m = $urandom_range(0, 9);
        if (m == 0) v = '1;
        else if (m == 1) v = '0;
        return v;
    endfunction

    for (genvar L = 0; L < 3; L++) begin : lane
        localparam int unsigned LN = (L == 0) ? 1 : (L == 1) ? 2 : 4;
        localparam int unsigned W  = 64 * LN;

        logic         rst       = 1'b1;
        logic         in_valid  = 1'b0;
        logic         in_sub    = 1'b0;
        logic         out_ready = 1'b0;
        logic [W-1:0] in_a      = '0;
        logic [W-1:0] in_b      = '0;
        logic         in_ready;
        logic         out_valid;
        logic         out_cout;
        logic [W-1:0] out_s;
`ifdef ADD_INT_SEQ_OVF_EN
        logic         out_ovf;
`endif
        logic         fin = 1'b0;
        exp_t         q[$];

        add_int_seq #(.LIMBS(LN)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_sub    (in_sub),
            .in_a      (in_a),
            .in_b      (in_b),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_s     (out_s),
            .out_cout  (out_cout)
`ifdef ADD_INT_SEQ_OVF_EN
            ,
            .out_ovf   (out_ovf)
`endif
        );

        task automatic scramble();
            logic [255:0] t;
            t      = rnd_val();
            in_a   = t[W-1:0];
            t      = rnd_val();
            in_b   = t[W-1:0];
            in_sub = 1'($urandom_range(0, 1));
        endtask

        // Entered and left just after a rising edge; pushes the expected result on accept.
        task automatic send(input logic [255:0] a, input logic [255:0] b, input logic sub);
            logic acc;
            acc      = 1'b0;
            in_valid = 1'b1;
            in_a     = a[W-1:0];
            in_b     = b[W-1:0];
            in_sub   = sub;
            for (int c = 0; c < 100 && !acc; c++) begin
                @(negedge clk);
                if (in_ready) begin
                    q.push_back(model(W, a, b, sub));
                    acc = 1'b1;
                end
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            scramble();
            check(L, "request accepted", 256'(acc), 256'd1);
        endtask

        // Counts edges after the accept edge until out_valid is seen; ends at a falling edge.
        task automatic wait_valid(output int lat);
            lat = -1;
            for (int c = 0; c < 100 && lat < 0; c++) begin
                @(negedge clk);
                if (out_valid) lat = c;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
        endtask

        // Monitor: every valid cycle is compared with the single outstanding result.
        initial begin
            forever begin
                @(negedge clk);
                if (out_valid) begin
                    check(L, "outstanding at out_valid", 256'(q.size()), 256'd1);
                    if (q.size() != 0) begin
                        check(L, "out_s", 256'(out_s), q[0].s);
                        check(L, "out_cout", 256'(out_cout), 256'(q[0].cout));
`ifdef ADD_INT_SEQ_OVF_EN
                        check(L, "out_ovf", 256'(out_ovf), 256'(q[0].ovf));
`endif
                        if (out_ready) void'(q.pop_front());
                    end
                end
            end
        end

        // Driver: reset, directed vectors, backpressure, reset mid-run, random traffic.
        initial begin
            int           lat;
            int           sent;
            int           cyc;
            logic         acc;
            logic [255:0] ra;
            logic [255:0] rb;
            logic         rs;

            rst       = 1'b1;
            out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check(L, "reset in_ready", 256'(in_ready), 256'd1);
            check(L, "reset out_valid", 256'(out_valid), 256'd0);
            check(L, "reset out_s", 256'(out_s), 256'd0);
            check(L, "reset out_cout", 256'(out_cout), 256'd0);
`ifdef ADD_INT_SEQ_OVF_EN
            check(L, "reset out_ovf", 256'(out_ovf), 256'd0);
`endif
            @(posedge clk);
            #1;

            for (int i = 0; i < 6; i++) begin
                send(DIR_A[i], DIR_B[i], DIR_SUB[i]);
                wait_valid(lat);
                check(L, "latency", 256'(lat), 256'(LN));
                @(negedge clk);
                check(L, "done single cycle", 256'(out_valid), 256'd0);
                check(L, "in_ready after result", 256'(in_ready), 256'd1);
                @(posedge clk);
                #1;
            end

            out_ready = 1'b0;
            send(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
            wait_valid(lat);
            check(L, "bp latency", 256'(lat), 256'(LN));
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                #1;
                in_valid = (k == 2);
                if (k == 2) scramble();
                @(negedge clk);
                check(L, "bp in_ready", 256'(in_ready), 256'd0);
                check(L, "bp out_valid", 256'(out_valid), 256'd1);
                if (q.size() != 0) check(L, "bp out_s held", 256'(out_s), q[0].s);
            end
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check(L, "in_ready during handshake", 256'(in_ready), 256'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check(L, "in_ready after handshake", 256'(in_ready), 256'd1);
            check(L, "out_valid after handshake", 256'(out_valid), 256'd0);
            @(posedge clk);
            #1;

            out_ready = 1'b0;
            send(rnd_val(), rnd_val(), 1'b1);
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            q.delete();
            @(negedge clk);
            check(L, "post-reset in_ready", 256'(in_ready), 256'd1);
            check(L, "post-reset out_valid", 256'(out_valid), 256'd0);
            check(L, "post-reset out_s", 256'(out_s), 256'd0);
            check(L, "post-reset out_cout", 256'(out_cout), 256'd0);
`ifdef ADD_INT_SEQ_OVF_EN
            check(L, "post-reset out_ovf", 256'(out_ovf), 256'd0);
`endif
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            send({256{1'b1}}, 256'd0, 1'b0);
            wait_valid(lat);
            check(L, "post-reset latency", 256'(lat), 256'(LN));
            @(posedge clk);
            #1;

            sent = 0;
            cyc  = 0;
            acc  = 1'b0;
            ra   = '0;
            rb   = '0;
            rs   = 1'b0;
            while ((sent < NREQ || q.size() != 0) && cyc < NREQ * 30) begin
                @(posedge clk);
                #1;
                cyc++;
                out_ready = ($urandom_range(0, 3) != 0);
                if (acc) begin
                    in_valid = 1'b0;
                    scramble();
                    acc = 1'b0;
                end
                if (!in_valid && sent < NREQ && $urandom_range(0, 2) != 0) begin
                    ra       = rnd_val();
                    rb       = rnd_val();
                    rs       = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                    in_a     = ra[W-1:0];
                    in_b     = rb[W-1:0];
                    in_sub   = rs;
                end
                @(negedge clk);
                if (in_valid && in_ready) begin
                    q.push_back(model(W, ra, rb, rs));
                    sent++;
                    acc = 1'b1;
                end
            end
            in_valid = 1'b0;
            check(L, "random requests issued", 256'(sent), 256'(NREQ));
            check(L, "random results drained", 256'(q.size()), 256'd0);
            fin = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(lane[0].fin && lane[1].fin && lane[2].fin) && cyc < 80000) begin
            @(posedge clk);
            cyc++;
        end
        check(-1, "all lanes finished",
              256'(lane[0].fin && lane[1].fin && lane[2].fin), 256'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
